kernel_cc_hls_deadlock_report_unit: RTL and testbench
=====================================================

// Module: kernel_cc_hls_deadlock_report_unit
// PURPOSE
//  Global arbiter downstream of the per-process deadlock detect units.
//  - Collects every unit's dl_detect_out and debounces the candidate deadlock.
//  - Launches one token from a chosen origin process.
//  - Accumulates the processes the token visits and stops it when it returns.
//  - Latches a sticky report (flag, origin id, process mask) for host/debug readout.
// PARAMETERS
//  PROC_NUM        4   number of dataflow processes / detect units
//  CONFIRM_CYCLES  16  cycles a candidate's dl_detect must stay high before trace (>=1)
//  TRACE_TIMEOUT   64  max cycles in TRACE before abandon (>= PROC_NUM+2)
//  ID_W  = max(1,$clog2(PROC_NUM))          (derived localparam)
// PORTS
//  reset             in   1         asynchronous, active-low
//  clock             in   1         clock
//  dl_detect_vec     in   PROC_NUM  dl_detect_out of detect unit i
//  token_vec         in   PROC_NUM  bit i = |token_out_vec of unit i
//  clear_report      in   1         sync clear; returns to IDLE
//  dl_detect_global  out  1         drives dl_detect_in of all units (registered)
//  origin_vec        out  PROC_NUM  one-hot, one-cycle origin pulse (registered)
//  token_clear_vec   out  PROC_NUM  combinational; same cycle as origin's dl_detect
//  deadlock          out  1         sticky deadlock-confirmed flag (registered)
//  dl_origin_id      out  ID_W      origin process index (registered)
//  dl_proc_mask      out  PROC_NUM  processes on the deadlock cycle (registered)
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0; counters 0.
//  FSM IDLE/CONFIRM/TRACE/REPORT; clear_report wins in any state -> IDLE next cycle.
//  - Clear wipes deadlock, mask, id and dl_detect_global.
//  IDLE
//  - If |dl_detect_vec: cand <= lowest set index; cnt <= 0; -> CONFIRM.
//  CONFIRM
//  - If !dl_detect_vec[cand] -> IDLE (glitch rejected).
//  - Else cnt++.
//  - At cnt==CONFIRM_CYCLES-1 -> TRACE:
//    - dl_detect_global <= 1; origin_vec <= onehot(cand);
//    - dl_origin_id <= cand; mask <= onehot(cand); tcnt <= 0.
//  TRACE
//  - origin_vec is high only in the first TRACE cycle, then 0.
//  - Each cycle: mask |= token_vec; tcnt++.
//  - dl_detect_vec ignored in the first TRACE cycle.
//  - Later dl_detect_vec[cand]==1 (token back at origin):
//    - token_clear_vec[cand]=1 that cycle;
//    - -> REPORT; deadlock <= 1; mask includes that cycle's token_vec.
//  - tcnt==TRACE_TIMEOUT-1 with no return -> IDLE:
//    - dl_detect_global <= 0; mask/id cleared; no report.
//  REPORT
//  - Hold deadlock, id, mask, dl_detect_global=1 until clear_report or reset.
//  - Inputs otherwise ignored.
//  token_clear_vec = 0 outside the TRACE return cycle; never more than one bit set.
//  Simultaneous candidates: lowest index wins; others ignored until IDLE.
//  Async reset mid-TRACE: immediate return to reset values, no partial report.
// CONFIGURATION
//  KERNEL_CC_DL_TIMESTAMP_EN defined:
//  - 32-bit free-running cycle counter, reset to 0, wraps at 2^32.
//  - Extra output dl_timestamp [31:0], reset 0.
//  - Loaded with the counter value on the cycle deadlock rises; cleared by clear_report.
//  Undefined: no counter, no dl_timestamp port; all other behaviour identical.
// STRUCTURE
//  Package kernel_cc_hls_deadlock_pkg holds:
//  - dl_state_t enum (IDLE, CONFIRM, TRACE, REPORT);
//  - id_width function; timestamp width constant (32).
//  Sub-module kernel_cc_hls_dl_prio_enc: lowest-index priority encoder.
//  - PROC_NUM in; valid + ID_W index out; combinational.
//  Top: FSM, CONFIRM/TRACE counters, mask accumulator, optional timestamp.
// TESTING
//  1 Reset: reset=0 mid-run -> all outputs 0, state IDLE, after release dl_detect_global=0.
//  2 Glitch: dl_detect_vec=4'b0100 for 5 cyc (CONFIRM_CYCLES=16)
//    -> back to IDLE, origin_vec never asserts, deadlock=0.
//  3 Full cycle: dl_detect_vec=4'b0010 held 16 cyc
//    -> origin_vec=4'b0010 for 1 cyc; token_vec visits 2,3.
//    -> dl_detect_vec[1] high 4 cyc later: token_clear_vec=4'b0010 that cycle.
//    -> deadlock=1, id=1, mask=4'b1110.
//  4 Priority: dl_detect_vec=4'b1010 held -> cand=1, dl_origin_id=1.
//  5 Timeout: token never returns -> after 64 TRACE cyc dl_detect_global=0, deadlock=0, IDLE.
//  6 Clear: in REPORT pulse clear_report 1 cyc -> next cycle deadlock=0, mask=0.
//    With KERNEL_CC_DL_TIMESTAMP_EN: dl_timestamp=0; before the clear it equals the cycle deadlock rose.

Source files
------------

// File: rtl/kernel_cc_hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock report unit.
// State encoding, id width helper and timestamp width.
package kernel_cc_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        DL_IDLE    = 2'd0,
        DL_CONFIRM = 2'd1,
        DL_TRACE   = 2'd2,
        DL_REPORT  = 2'd3
    } dl_state_t;

    localparam int DL_TS_W = 32;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kernel_cc_hls_dl_prio_enc.sv
// Lowest-index priority encoder used to pick the deadlock candidate.
// Combinational: valid when any bit is set, idx of the lowest set bit.
module kernel_cc_hls_dl_prio_enc
    import kernel_cc_hls_deadlock_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    vec_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = ID_W'(i);
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/kernel_cc_hls_deadlock_report_unit.sv
// Global deadlock arbiter: debounce, token launch, trace, sticky report.
// Optional cycle timestamp of the report under KERNEL_CC_DL_TIMESTAMP_EN.
module kernel_cc_hls_deadlock_report_unit
    import kernel_cc_hls_deadlock_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TRACE_TIMEOUT  = 64,
    localparam int ID_W = id_width(PROC_NUM)
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_vec,
    input  logic                clear_report,
    output logic                dl_detect_global,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear_vec,
    output logic                deadlock,
    output logic [ID_W-1:0]     dl_origin_id,
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
    output logic [PROC_NUM-1:0] dl_proc_mask,
    output logic [DL_TS_W-1:0]  dl_timestamp
`else
    output logic [PROC_NUM-1:0] dl_proc_mask
`endif
);

    localparam int CNT_W  = $clog2(CONFIRM_CYCLES + 1);
    localparam int TCNT_W = $clog2(TRACE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRACE_TIMEOUT - 1);

    dl_state_t           state_q, state_d;
    logic [ID_W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                glb_q, glb_d;
    logic [PROC_NUM-1:0] origin_q, origin_d;
    logic                dead_q, dead_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [PROC_NUM-1:0] mask_q, mask_d;
    logic [PROC_NUM-1:0] tclr;
    logic [PROC_NUM-1:0] cand_oh;
    logic                cand_hit;
    logic                enc_valid;
    logic [ID_W-1:0]     enc_idx;

    kernel_cc_hls_dl_prio_enc #(
        .N (PROC_NUM)
    ) u_enc (
        .vec_i   (dl_detect_vec),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // One-hot view of the held candidate and whether it still detects.
    always_comb begin
        cand_oh = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            cand_oh[i] = (cand_q == ID_W'(i));
        end
    end

    assign cand_hit = |(dl_detect_vec & cand_oh);

    // Next-state logic: debounce, launch, trace and report.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        glb_d    = glb_q;
        origin_d = '0;
        dead_d   = dead_q;
        id_d     = id_q;
        mask_d   = mask_q;
        tclr     = '0;
        if (clear_report) begin
            state_d = DL_IDLE;
            glb_d   = 1'b0;
            dead_d  = 1'b0;
            id_d    = '0;
            mask_d  = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
        end else begin
            unique case (state_q)
                DL_IDLE: begin
                    if (enc_valid) begin
                        cand_d  = enc_idx;
                        cnt_d   = '0;
                        state_d = DL_CONFIRM;
                    end
                end
                DL_CONFIRM: begin
                    if (!cand_hit) begin
                        state_d = DL_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = DL_TRACE;
                        glb_d    = 1'b1;
                        origin_d = cand_oh;
                        id_d     = cand_q;
                        mask_d   = cand_oh;
                        tcnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DL_TRACE: begin
                    mask_d = mask_q | token_vec;
                    tcnt_d = tcnt_q + 1'b1;
                    // First trace cycle still sees the launch detect level.
                    if (tcnt_q != '0 && cand_hit) begin
                        tclr    = cand_oh;
                        state_d = DL_REPORT;
                        dead_d  = 1'b1;
                    end else if (tcnt_q == TCNT_LAST) begin
                        state_d = DL_IDLE;
                        glb_d   = 1'b0;
                        mask_d  = '0;
                        id_d    = '0;
                    end
                end
                DL_REPORT: begin
                end
                default: state_d = DL_IDLE;
            endcase
        end
    end

    // State and report registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= DL_IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            glb_q    <= 1'b0;
            origin_q <= '0;
            dead_q   <= 1'b0;
            id_q     <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            glb_q    <= glb_d;
            origin_q <= origin_d;
            dead_q   <= dead_d;
            id_q     <= id_d;
            mask_q   <= mask_d;
        end
    end

`ifdef KERNEL_CC_DL_TIMESTAMP_EN
    logic [DL_TS_W-1:0] ts_cnt_q;
    logic [DL_TS_W-1:0] ts_q, ts_d;

    // Capture the free-running count when the report rises.
    always_comb begin
        ts_d = ts_q;
        if (clear_report) ts_d = '0;
        else if (dead_d && !dead_q) ts_d = ts_cnt_q;
    end

    // Free-running cycle counter and latched timestamp.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            ts_q     <= ts_d;
        end
    end

    assign dl_timestamp = ts_q;
`endif

    assign dl_detect_global = glb_q;
    assign origin_vec       = origin_q;
    assign token_clear_vec  = tclr;
    assign deadlock         = dead_q;
    assign dl_origin_id     = id_q;
    assign dl_proc_mask     = mask_q;

endmodule

// File: tb/tb_kernel_cc_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit.
// Covers reset, glitch reject, full trace, priority, timeout, clear.
module tb_kernel_cc_hls_deadlock_report_unit;

    logic       reset;
    logic       clock;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_vec;
    logic       clear_report;
    logic       dl_detect_global;
    logic [3:0] origin_vec;
    logic [3:0] token_clear_vec;
    logic       deadlock;
    logic [1:0] dl_origin_id;
    logic [3:0] dl_proc_mask;
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
    logic [31:0] dl_timestamp;
    logic [31:0] cyc;
    logic [31:0] ts_exp;
`endif

    int n_chk;
    int n_err;
    int seen;

    kernel_cc_hls_deadlock_report_unit dut (
        .reset            (reset),
        .clock            (clock),
        .dl_detect_vec    (dl_detect_vec),
        .token_vec        (token_vec),
        .clear_report     (clear_report),
        .dl_detect_global (dl_detect_global),
        .origin_vec       (origin_vec),
        .token_clear_vec  (token_clear_vec),
        .deadlock         (deadlock),
        .dl_origin_id     (dl_origin_id),
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
        .dl_proc_mask     (dl_proc_mask),
        .dl_timestamp     (dl_timestamp)
`else
        .dl_proc_mask     (dl_proc_mask)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef KERNEL_CC_DL_TIMESTAMP_EN
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= '0;
        else cyc <= cyc + 1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        dl_detect_vec = '0;
        token_vec = '0;
        clear_report = 1'b0;
        tick();
        tick();
        check("rst_glb", 32'(dl_detect_global), 32'd0);
        check("rst_origin", 32'(origin_vec), 32'd0);
        check("rst_dead", 32'(deadlock), 32'd0);
        check("rst_mask", 32'(dl_proc_mask), 32'd0);
        check("rst_id", 32'(dl_origin_id), 32'd0);
        check("rst_tclr", 32'(token_clear_vec), 32'd0);
        reset = 1'b1;
        tick();

        // Glitch: 5 cycles of candidate 2 must not launch.
        seen = 0;
        dl_detect_vec = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (origin_vec != 0) seen++;
        end
        dl_detect_vec = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (origin_vec != 0) seen++;
        end
        check("glitch_origin", 32'(seen), 32'd0);
        check("glitch_dead", 32'(deadlock), 32'd0);
        check("glitch_glb", 32'(dl_detect_global), 32'd0);

        // Full cycle from origin 1 through 2 and 3.
        seen = 0;
        dl_detect_vec = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (origin_vec != 0) seen++;
        end
        check("full_early_origin", 32'(seen), 32'd0);
        tick();
        check("full_origin", 32'(origin_vec), 32'h2);
        check("full_glb", 32'(dl_detect_global), 32'd1);
        check("full_id_launch", 32'(dl_origin_id), 32'd1);
        check("full_mask_launch", 32'(dl_proc_mask), 32'h2);
        dl_detect_vec = '0;
        token_vec = 4'b0100;
        tick();
        check("full_origin_pulse", 32'(origin_vec), 32'd0);
        check("full_mask_2", 32'(dl_proc_mask), 32'h6);
        token_vec = 4'b1000;
        tick();
        check("full_mask_3", 32'(dl_proc_mask), 32'he);
        token_vec = '0;
        tick();
        check("full_tclr_idle", 32'(token_clear_vec), 32'd0);
        tick();
        dl_detect_vec = 4'b0010;
        token_vec = 4'b0010;
        #1;
        check("full_tclr", 32'(token_clear_vec), 32'h2);
        check("full_dead_pre", 32'(deadlock), 32'd0);
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
        ts_exp = cyc;
`endif
        tick();
        dl_detect_vec = '0;
        token_vec = '0;
        #1;
        check("full_dead", 32'(deadlock), 32'd1);
        check("full_id", 32'(dl_origin_id), 32'd1);
        check("full_mask", 32'(dl_proc_mask), 32'he);
        check("full_tclr_after", 32'(token_clear_vec), 32'd0);
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
        check("full_ts", dl_timestamp, ts_exp);
`endif
        // Report holds while inputs wiggle.
        dl_detect_vec = 4'b1111;
        token_vec = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        check("hold_dead", 32'(deadlock), 32'd1);
        check("hold_mask", 32'(dl_proc_mask), 32'he);
        check("hold_glb", 32'(dl_detect_global), 32'd1);
        check("hold_tclr", 32'(token_clear_vec), 32'd0);
        dl_detect_vec = '0;
        token_vec = '0;

        // Clear returns everything to idle.
        clear_report = 1'b1;
        tick();
        clear_report = 1'b0;
        check("clr_dead", 32'(deadlock), 32'd0);
        check("clr_mask", 32'(dl_proc_mask), 32'd0);
        check("clr_id", 32'(dl_origin_id), 32'd0);
        check("clr_glb", 32'(dl_detect_global), 32'd0);
`ifdef KERNEL_CC_DL_TIMESTAMP_EN
        check("clr_ts", dl_timestamp, 32'd0);
`endif

        // Priority: 1 and 3 together, 1 wins; then timeout.
        dl_detect_vec = 4'b1010;
        for (int i = 0; i < 17; i++) tick();
        check("prio_origin", 32'(origin_vec), 32'h2);
        check("prio_id", 32'(dl_origin_id), 32'd1);
        dl_detect_vec = 4'b1000;
        for (int i = 0; i < 63; i++) tick();
        check("to_glb_hold", 32'(dl_detect_global), 32'd1);
        dl_detect_vec = '0;
        tick();
        check("to_glb", 32'(dl_detect_global), 32'd0);
        check("to_dead", 32'(deadlock), 32'd0);
        check("to_id", 32'(dl_origin_id), 32'd0);
        check("to_mask", 32'(dl_proc_mask), 32'd0);

        // Async reset in the middle of a trace.
        dl_detect_vec = 4'b0001;
        for (int i = 0; i < 17; i++) tick();
        check("mid_origin", 32'(origin_vec), 32'h1);
        dl_detect_vec = '0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_glb", 32'(dl_detect_global), 32'd0);
        check("mid_rst_mask", 32'(dl_proc_mask), 32'd0);
        check("mid_rst_dead", 32'(deadlock), 32'd0);
        tick();
        reset = 1'b1;
        dl_detect_vec = 4'b0001;
        tick();
        tick();
        check("mid_rel_glb", 32'(dl_detect_global), 32'd0);
        check("mid_rel_tclr", 32'(token_clear_vec), 32'd0);
        check("mid_rel_origin", 32'(origin_vec), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
